// File: rtl/stopwatch_display_scan.sv
// ---------------------------------------------------------------------------
// stopwatch_display_scan
//
// Purpose:
//   Takes the stopwatch's binary minutes / seconds / centiseconds and shows
//   them as MM SS CC on a multiplexed 6-digit seven-segment display. Each
//   digit slot lasts CLK_DIV clock cycles. The inputs are captured once per
//   scan frame, so a single frame never mixes an old and a new time value.
//
// Ports:
//   clk_core  in   1  system clock
//   rst       in   1  synchronous active-high reset
//   min_i     in   6  minutes, binary (valid 0..59)
//   sec_i     in   6  seconds, binary (valid 0..59)
//   ms_10_i   in   7  centiseconds, binary (valid 0..99)
//   dp_en     in   1  enables decimal points after min-units and sec-units
//   an        out  6  digit enables, an[5]=min tens ... an[0]=cs units
//   seg       out  7  segments {g,f,e,d,c,b,a}
//   dp        out  1  decimal point
//
// Parameters:
//   CLK_DIV         clock cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1: seg/dp low = lit, 0: high = lit
//   AN_ACTIVE_LOW   1: an bit low = digit on, 0: high = digit on
// ---------------------------------------------------------------------------
module stopwatch_display_scan #(
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [6:0] ms_10_i,
  input  logic       dp_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

  localparam logic [5:0] AN_BLANK  = AN_ACTIVE_LOW  ? 6'b111111  : 6'b000000;
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic       DP_BLANK  = SEG_ACTIVE_LOW;

  logic [CW-1:0] count;
  logic          tick;
  logic [2:0]    idx;

  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [6:0] snap_ms;

  logic [6:0] field_val;
  logic       field_bad;
  logic       use_tens;
  logic [6:0] digit;
  logic [6:0] seg_hi;
  logic       dp_hi;
  logic [5:0] an_onehot;
  logic [5:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // Active-high glyph for a decimal digit; anything else falls back to a dash.
  function automatic logic [6:0] glyph(input logic [6:0] d);
    case (d)
      7'd0:    glyph = 7'b0111111;
      7'd1:    glyph = 7'b0000110;
      7'd2:    glyph = 7'b1011011;
      7'd3:    glyph = 7'b1001111;
      7'd4:    glyph = 7'b1100110;
      7'd5:    glyph = 7'b1101101;
      7'd6:    glyph = 7'b1111101;
      7'd7:    glyph = 7'b0000111;
      7'd8:    glyph = 7'b1111111;
      7'd9:    glyph = 7'b1101111;
      default: glyph = GLYPH_DASH;
    endcase
  endfunction

  // Prescaler: one tick per digit slot.
  assign tick = (count == LAST_COUNT);

  always_ff @(posedge clk_core) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Digit slot index, 0 = cs units up to 5 = min tens.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      idx <= 3'd0;
    end else if (tick) begin
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end

  // The snapshot is taken on the tick that shows the last digit of a frame.
  // That digit still uses the old snapshot, since the output registers and
  // the snapshot load on the same edge, and the next frame sees the new one.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      snap_min <= '0;
      snap_sec <= '0;
      snap_ms  <= '0;
    end else if (tick && (idx == 3'd5)) begin
      snap_min <= min_i;
      snap_sec <= sec_i;
      snap_ms  <= ms_10_i;
    end
  end

  // Pick the field for the current slot, split it into tens/units and
  // replace both digits of an out-of-range field with a dash.
  always_comb begin
    field_val = {1'b0, snap_ms};
    field_bad = 1'b0;
    use_tens  = 1'b0;
    case (idx)
      3'd0: begin
        field_val = snap_ms;
        field_bad = (snap_ms > 7'd99);
        use_tens  = 1'b0;
      end
      3'd1: begin
        field_val = snap_ms;
        field_bad = (snap_ms > 7'd99);
        use_tens  = 1'b1;
      end
      3'd2: begin
        field_val = {1'b0, snap_sec};
        field_bad = (snap_sec > 6'd59);
        use_tens  = 1'b0;
      end
      3'd3: begin
        field_val = {1'b0, snap_sec};
        field_bad = (snap_sec > 6'd59);
        use_tens  = 1'b1;
      end
      3'd4: begin
        field_val = {1'b0, snap_min};
        field_bad = (snap_min > 6'd59);
        use_tens  = 1'b0;
      end
      3'd5: begin
        field_val = {1'b0, snap_min};
        field_bad = (snap_min > 6'd59);
        use_tens  = 1'b1;
      end
      default: begin
        field_val = 7'd0;
        field_bad = 1'b1;
        use_tens  = 1'b0;
      end
    endcase

    digit  = use_tens ? (field_val / 7'd10) : (field_val % 7'd10);
    seg_hi = field_bad ? GLYPH_DASH : glyph(digit);

    dp_hi = dp_en && ((idx == 3'd4) || (idx == 3'd2));

    an_onehot = 6'b000001 << idx;
    an_next   = AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;
    seg_next  = SEG_ACTIVE_LOW ? ~seg_hi    : seg_hi;
    dp_next   = SEG_ACTIVE_LOW ? ~dp_hi     : dp_hi;
  end

  // Output registers: load only on tick, hold for the rest of the slot.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      an  <= AN_BLANK;
      seg <= SEG_BLANK;
      dp  <= DP_BLANK;
    end else if (tick) begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
